// File: rtl/csi_vc_scheduler_if.sv
// Stream bundle for csi_vc_scheduler: lane-receiver word input, packet output, status.
// The slave side is the scheduler. The master side is the lane receiver plus the downstream sink.
interface csi_vc_scheduler_if;
    logic        in_valid;
    logic [1:0]  in_vc;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_vc;
    logic        out_last;
    logic        out_error;
    logic [3:0]  overflow;
    logic        clear_overflow;
    logic [15:0] drop_count;

    modport slave (
        input  in_valid, in_vc, in_data, in_last, out_ready, clear_overflow,
        output out_valid, out_data, out_vc, out_last, out_error, overflow, drop_count
    );
    modport master (
        output in_valid, in_vc, in_data, in_last, out_ready, clear_overflow,
        input  out_valid, out_data, out_vc, out_last, out_error, overflow, drop_count
    );
endinterface

// File: rtl/csi_vc_scheduler.sv
// Per-VC show-ahead FIFOs with a packet-atomic round-robin drain. First word appears 2 cycles after it is presented.
// The input cannot be stalled, so overflow drops the remaining words and queues an error terminator. The output uses valid/ready.
module csi_vc_scheduler #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [3:0] VC_ENABLE  = 4'b1111
) (
    input  logic               clock_p,
    input  logic               reset,
    csi_vc_scheduler_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] W_ACCEPT    = 2'd0;
    localparam logic [1:0] W_DROP_FULL = 2'd1;
    localparam logic [1:0] W_DROP_TAIL = 2'd2;
    localparam logic [0:0] A_IDLE      = 1'b0;
    localparam logic [0:0] A_LOCKED    = 1'b1;

    logic [33:0]          mem_q [4][FIFO_DEPTH];
    logic [3:0][AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0][1:0]      wst_q, wst_d;
    logic [3:0]           tail_q, tail_d;
    logic [3:0]           ovf_q, ovf_d;
    logic [15:0]          drop_q, drop_d;
    logic [0:0]           arb_q, arb_d;
    logic [1:0]           grant_q, grant_d, last_q, last_d;
    logic [3:0]           full, empty, hit, push;
    logic [3:0][33:0]     wdat;
    logic                 any_drop, found, pop;
    logic [1:0]           cand;
    logic [33:0]          head;
    logic                 out_valid, out_last, out_error;
    logic [31:0]          out_data;
    logic [1:0]           out_vc;

    // Write side: full is judged on registered pointers, so a same-cycle pop never rescues a push.
    always_comb begin
        wst_d    = wst_q;
        tail_d   = tail_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q & ~{4{bus.clear_overflow}};
        push     = '0;
        wdat     = '0;
        any_drop = 1'b0;
        full     = '0;
        empty    = '0;
        hit      = '0;
        for (int v = 0; v < 4; v++) begin
            full[v]  = (wr_ptr_q[v] ^ rd_ptr_q[v]) == {1'b1, {AW{1'b0}}};
            empty[v] = wr_ptr_q[v] == rd_ptr_q[v];
            hit[v]   = bus.in_valid && (bus.in_vc == 2'(v)) && VC_ENABLE[v];
            case (wst_q[v])
                W_ACCEPT: begin
                    if (hit[v] && !full[v]) begin
                        push[v] = 1'b1;
                        wdat[v] = {1'b0, bus.in_last, bus.in_data};
                    end else if (hit[v]) begin
                        any_drop  = 1'b1;
                        ovf_d[v]  = 1'b1;
                        tail_d[v] = bus.in_last;
                        wst_d[v]  = W_DROP_FULL;
                    end
                end
                W_DROP_FULL: begin
                    any_drop = any_drop | hit[v];
                    if (!full[v]) begin
                        push[v]  = 1'b1;
                        wdat[v]  = {2'b11, 32'h0};
                        wst_d[v] = (tail_q[v] || (hit[v] && bus.in_last)) ? W_ACCEPT : W_DROP_TAIL;
                    end else if (hit[v] && bus.in_last) begin
                        tail_d[v] = 1'b1;
                    end
                end
                W_DROP_TAIL: begin
                    any_drop = any_drop | hit[v];
                    if (hit[v] && bus.in_last)
                        wst_d[v] = W_ACCEPT;
                end
                default: wst_d[v] = W_ACCEPT;
            endcase
            if (push[v])
                wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
        end
        drop_d = (any_drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    // Arbiter: a grant is held until the packet's last word leaves, even across an empty FIFO.
    always_comb begin
        arb_d     = arb_q;
        grant_d   = grant_q;
        last_d    = last_q;
        rd_ptr_d  = rd_ptr_q;
        found     = 1'b0;
        cand      = '0;
        pop       = 1'b0;
        head      = mem_q[grant_q][rd_ptr_q[grant_q][AW-1:0]];
        out_valid = 1'b0;
        out_data  = '0;
        out_vc    = '0;
        out_last  = 1'b0;
        out_error = 1'b0;
        if (arb_q == A_IDLE) begin
            for (int i = 1; i <= 4; i++) begin
                cand = last_q + 2'(i);
                if (!found && !empty[cand]) begin
                    found   = 1'b1;
                    grant_d = cand;
                end
            end
            if (found)
                arb_d = A_LOCKED;
        end else if (!empty[grant_q]) begin
            out_valid = 1'b1;
            out_data  = head[31:0];
            out_vc    = grant_q;
            out_last  = head[32];
            out_error = head[33];
            pop       = bus.out_ready;
            if (pop) begin
                rd_ptr_d[grant_q] = rd_ptr_q[grant_q] + 1'b1;
                if (head[32]) begin
                    arb_d  = A_IDLE;
                    last_d = grant_q;
                end
            end
        end
    end

    always_ff @(posedge clock_p) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wst_q    <= {4{W_ACCEPT}};
            tail_q   <= '0;
            ovf_q    <= '0;
            drop_q   <= '0;
            arb_q    <= A_IDLE;
            grant_q  <= '0;
            last_q   <= 2'd3;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wst_q    <= wst_d;
            tail_q   <= tail_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            arb_q    <= arb_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clock_p) begin
        for (int v = 0; v < 4; v++)
            if (push[v])
                mem_q[v][wr_ptr_q[v][AW-1:0]] <= wdat[v];
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.out_vc     = out_vc;
    assign bus.out_last   = out_last;
    assign bus.out_error  = out_error;
    assign bus.overflow   = ovf_q;
    assign bus.drop_count = drop_q;
endmodule
